// File: rtl/debounce_sync.sv
// Input conditioning: 2-flop synchronizer followed by a glitch-rejecting debounce
// counter, producing a clean level plus one-cycle rise/fall pulses and a busy flag.
module debounce_sync #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DEB_CYC = 4,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    // Synchronizer and debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= RST_VAL;
            s2_q    <= RST_VAL;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            q_q     <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= d;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Qualify a level change: it must persist DEB_CYC consecutive cycles on s2
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s2_q != q_q) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHECK: begin
                if (s2_q == q_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    q_d     = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed latency/glitch/reset scenarios plus random
// stimulus, checked against a mismatch-streak reference model.
module tb_debounce_sync;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEB_CYC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic d     = 1'b0;
    logic q, rise, fall, busy;

    int checks   = 0;
    int failures = 0;

    debounce_sync #(
        .CNT_W  (CNT_W),
        .DEB_CYC(DEB_CYC),
        .RST_VAL(1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #100 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: q flips once s2 has disagreed with q for DEB_CYC edges in a row
    bit m_s1 = 0, m_s2 = 0, m_q = 0, m_rise = 0, m_fall = 0, m_busy = 0;
    int run = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_q = 0;
            m_rise = 0; m_fall = 0; m_busy = 0;
            run = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (m_s2 != m_q) begin
                run++;
                if (run == int'(DEB_CYC)) begin
                    m_q    = m_s2;
                    m_rise = m_s2;
                    m_fall = !m_s2;
                    run    = 0;
                end
            end else begin
                run = 0;
            end
            m_busy = (run != 0);
            m_s2   = m_s1;
            m_s1   = d;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q",    int'(q),    int'(m_q));
            chk("model_rise", int'(rise), int'(m_rise));
            chk("model_fall", int'(fall), int'(m_fall));
            chk("model_busy", int'(busy), int'(m_busy));
            chk("rise_fall_excl", int'(rise & fall), 0);
        end
    end

    // Drive a new level and report the edge index (first edge = capture) of busy and q
    task automatic measure(input logic val, output int lat_q, output int lat_busy);
        lat_q    = 0;
        lat_busy = 0;
        @(negedge clk);
        d = val;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (busy && lat_busy == 0) lat_busy = i;
            if (q === val && lat_q == 0) lat_q = i;
        end
    endtask

    int lq, lb;

    initial begin
        chk_en = 1;
        // Reset held with d=1
        d     = 1'b1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_q", int'(q), 0);
            chk("rst_busy", int'(busy), 0);
        end
        d     = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_exit_q", int'(q), 0);
            chk("rst_exit_pulse", int'(rise | fall), 0);
        end

        // Clean rise
        measure(1'b1, lq, lb);
        chk("rise_lat_q", lq, int'(DEB_CYC) + 2);
        chk("rise_lat_busy", lb, 3);
        chk("rise_busy_done", int'(busy), 0);

        // Clean fall
        measure(1'b0, lq, lb);
        chk("fall_lat_q", lq, int'(DEB_CYC) + 2);

        // Glitch of 3 cycles
        @(negedge clk);
        d = 1'b1;
        repeat (3) @(negedge clk);
        d = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch_q", int'(q), 0);
        chk("glitch_busy", int'(busy), 0);

        // Reset mid-qualification (cnt=2 after edge k+3)
        @(negedge clk);
        d = 1'b1;
        repeat (4) @(posedge clk);
        #50;
        chk("midq_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midq_async_busy", int'(busy), 0);
        chk("midq_async_q", int'(q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lq = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (q && lq == 0) lq = i;
        end
        chk("midq_requal_lat", lq, int'(DEB_CYC) + 2);

        // Return to q=0, then chatter every cycle
        measure(1'b0, lq, lb);
        chk("pre_chatter_lat", lq, int'(DEB_CYC) + 2);
        repeat (20) begin
            @(negedge clk);
            d = ~d;
            chk("chatter_q", int'(q), 0);
            chk("chatter_pulse", int'(rise | fall), 0);
        end
        @(negedge clk);
        d = 1'b0;
        repeat (6) @(negedge clk);

        // Random levels with random hold times and occasional async reset
        repeat (60) begin
            d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) begin
                #30 rst_n = 1'b0;
                #20 rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end

        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
